// File: rtl/vga_disp_timing_gen.sv
// vga_disp_timing_gen: parametrised VGA/LCD timing generator with a registered pixel output stage
// and sticky underrun detection on the upstream pixel stream.
module vga_disp_timing_gen #(
   parameter int   COLOR_W   = 8,
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CNT_W     = 12
) (
   input  logic                 clk_p,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 pix_valid_i,
   input  logic [3*COLOR_W-1:0] pix_data_i,
   output logic                 pix_ready_o,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic                 csync_o,
   output logic                 blank_o,
   output logic [COLOR_W-1:0]   red_o,
   output logic [COLOR_W-1:0]   green_o,
   output logic [COLOR_W-1:0]   blue_o,
   output logic [CNT_W-1:0]     hcnt_o,
   output logic [CNT_W-1:0]     vcnt_o,
   output logic                 sof_o,
   output logic                 underrun_o,
   input  logic                 underrun_clr_i
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] hcnt, vcnt;
   logic active, h_sync_act, v_sync_act, h_wrap, v_wrap;

   // Every qualifier is gated by en_i so a disabled generator produces idle outputs.
   always_comb begin
      h_wrap     = hcnt == CNT_W'(H_TOTAL - 1);
      v_wrap     = vcnt == CNT_W'(V_TOTAL - 1);
      active     = en_i && hcnt < CNT_W'(H_ACTIVE) && vcnt < CNT_W'(V_ACTIVE);
      h_sync_act = en_i && hcnt >= CNT_W'(H_ACTIVE + H_FP) && hcnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
      v_sync_act = en_i && vcnt >= CNT_W'(V_ACTIVE + V_FP) && vcnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   end

   assign pix_ready_o = active;
   assign hcnt_o      = hcnt;
   assign vcnt_o      = vcnt;

   always_ff @(posedge clk_p or posedge rst_i) begin
      if (rst_i) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (!en_i) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         hcnt <= h_wrap ? '0 : hcnt + 1'b1;
         if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      end
   end

   always_ff @(posedge clk_p or posedge rst_i) begin
      if (rst_i) begin
         hsync_o    <= ~HSYNC_POL;
         vsync_o    <= ~VSYNC_POL;
         csync_o    <= ~HSYNC_POL;
         blank_o    <= 1'b1;
         red_o      <= '0;
         green_o    <= '0;
         blue_o     <= '0;
         sof_o      <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         hsync_o                 <= h_sync_act ? HSYNC_POL : ~HSYNC_POL;
         vsync_o                 <= v_sync_act ? VSYNC_POL : ~VSYNC_POL;
         csync_o                 <= (h_sync_act ^ v_sync_act) ? HSYNC_POL : ~HSYNC_POL;
         blank_o                 <= ~active;
         {red_o, green_o, blue_o} <= (active && pix_valid_i) ? pix_data_i : '0;
         sof_o                   <= en_i && hcnt == '0 && vcnt == '0;
         // Set has priority over a simultaneous clear.
         underrun_o              <= (active && !pix_valid_i) ? 1'b1 : underrun_clr_i ? 1'b0 : underrun_o;
      end
   end
endmodule

// File: tb/tb_vga_disp_timing_gen.sv
// tb_vga_disp_timing_gen: random stimulus against a frame-position reference model on a small
// timing configuration with mixed sync polarities.
module tb_vga_disp_timing_gen;
   localparam int CW = 8, HA = 4, HF = 1, HS = 2, HB = 1, VA = 2, VF = 1, VS = 1, VB = 1, NW = 12;
   localparam logic HP = 1'b1, VP = 1'b0;
   localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;

   logic clk_p = 0, rst_i = 1, en_i = 0, pix_valid_i = 0, underrun_clr_i = 0;
   logic [3*CW-1:0] pix_data_i = '0;
   logic pix_ready_o, hsync_o, vsync_o, csync_o, blank_o, sof_o, underrun_o;
   logic [CW-1:0] red_o, green_o, blue_o;
   logic [NW-1:0] hcnt_o, vcnt_o;

   vga_disp_timing_gen #(
      .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(NW)
   ) dut (
      .clk_p(clk_p), .rst_i(rst_i), .en_i(en_i), .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i),
      .pix_ready_o(pix_ready_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .csync_o(csync_o),
      .blank_o(blank_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .hcnt_o(hcnt_o), .vcnt_o(vcnt_o), .sof_o(sof_o), .underrun_o(underrun_o),
      .underrun_clr_i(underrun_clr_i)
   );

   always #5 clk_p = ~clk_p;

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected registered outputs, one cycle ahead of the DUT.
   logic e_hs, e_vs, e_cs, e_blank, e_sof, e_under;
   logic [3*CW-1:0] e_rgb;
   int pos, hm, vm, accepts;

   task automatic expect_reset();
      e_hs = ~HP; e_vs = ~VP; e_cs = ~HP; e_blank = 1; e_rgb = '0; e_sof = 0; e_under = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_hsync"}, 32'(hsync_o), 32'(e_hs));
      check({tag, "_vsync"}, 32'(vsync_o), 32'(e_vs));
      check({tag, "_csync"}, 32'(csync_o), 32'(e_cs));
      check({tag, "_blank"}, 32'(blank_o), 32'(e_blank));
      check({tag, "_rgb"}, 32'({red_o, green_o, blue_o}), 32'(e_rgb));
      check({tag, "_sof"}, 32'(sof_o), 32'(e_sof));
      check({tag, "_underrun"}, 32'(underrun_o), 32'(e_under));
   endtask

   initial begin
      logic act, hsa, vsa;
      expect_reset();
      pos = 0;
      accepts = 0;
      #12;
      check_regs("reset");
      check("reset_hcnt", 32'(hcnt_o), 0);
      check("reset_vcnt", 32'(vcnt_o), 0);
      @(negedge clk_p);
      rst_i = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_p);
         check_regs("out");
         if (cyc < 2 * HT * VT) begin
            en_i = 1; pix_valid_i = 1; underrun_clr_i = 0;
         end else begin
            en_i = $urandom_range(0, 29) != 0;
            pix_valid_i = $urandom_range(0, 7) != 0;
            underrun_clr_i = $urandom_range(0, 9) == 0;
         end
         pix_data_i = (cyc == 0) ? 24'h112233 : 24'($urandom);
         #1;
         if (cyc >= 2 * HT * VT && $urandom_range(0, 299) == 0) begin
            #1 rst_i = 1;
            #1;
            expect_reset();
            pos = 0;
            check_regs("async_rst");
            check("async_rst_hcnt", 32'(hcnt_o), 0);
            #1 rst_i = 0;
         end
         hm = pos % HT;
         vm = (pos / HT) % VT;
         act = en_i && hm < HA && vm < VA;
         hsa = en_i && hm >= HA + HF && hm < HA + HF + HS;
         vsa = en_i && vm >= VA + VF && vm < VA + VF + VS;
         check("hcnt", 32'(hcnt_o), 32'(hm));
         check("vcnt", 32'(vcnt_o), 32'(vm));
         check("ready", 32'(pix_ready_o), 32'(act));
         if (cyc >= HT * VT && cyc < 2 * HT * VT && pix_ready_o) accepts++;
         if (cyc == 2 * HT * VT) check("accepts_per_frame", 32'(accepts), 32'(HA * VA));
         e_hs = hsa ? HP : ~HP;
         e_vs = vsa ? VP : ~VP;
         e_cs = (hsa ^ vsa) ? HP : ~HP;
         e_blank = ~act;
         e_rgb = (act && pix_valid_i) ? pix_data_i : '0;
         e_sof = en_i && hm == 0 && vm == 0;
         e_under = (act && !pix_valid_i) ? 1'b1 : underrun_clr_i ? 1'b0 : e_under;
         pos = en_i ? pos + 1 : 0;
      end
      @(negedge clk_p);
      check_regs("final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
